// File: rtl/csr_spmv_pkg.sv
// Shared constants and FSM state encoding for the CSR sparse matrix-vector engine.
package csr_spmv_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 32;
  localparam int DEF_RW = 16;

  typedef enum logic [2:0] {
    IDLE,
    RP0,
    RP1,
    FETCH,
    MUL,
    EMIT
  } state_t;

endpackage

// File: rtl/csr_mac.sv
// Multiply-accumulate with synchronous clear; product and sum wrap at DW bits.
module csr_mac
  import csr_spmv_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + a * b;
    end
  end

endmodule

// File: rtl/csr_spmv_engine.sv
// CSR sparse matrix times dense vector engine: walks row pointers, accumulates
// val*vec per nonzero and streams one result per row in ascending row order.
module csr_spmv_engine
  import csr_spmv_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int RW = DEF_RW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [RW-1:0] num_rows,
  input  logic [AW-1:0] row_base,
  input  logic [AW-1:0] col_base,
  input  logic [AW-1:0] val_base,
  input  logic [AW-1:0] vec_base,
  output logic [AW-1:0] addr1,
  input  logic [DW-1:0] dataIn1,
  output logic [AW-1:0] addr2,
  input  logic [DW-1:0] dataIn2,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [RW-1:0] res_row,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state;
  logic [RW-1:0] rows;
  logic [RW-1:0] r;
  logic [AW-1:0] rb, cb, vb, xb;
  logic [DW-1:0] k, end_ptr, col, val;
  logic [DW-1:0] acc;
  logic [DW:0]   k_next;
  logic [RW:0]   r_next;

  assign k_next = {1'b0, k} + (DW+1)'(1);
  assign r_next = {1'b0, r} + (RW+1)'(1);

  csr_mac #(.DW(DW)) u_mac (
    .Clk (Clk),
    .Rst (Rst),
    .clr (state == RP1),
    .en  (state == MUL),
    .a   (val),
    .b   (dataIn2),
    .acc (acc)
  );

  // Memory reads are combinational, so addresses are pure decodes of state.
  always_comb begin
    addr1 = '0;
    addr2 = '0;
    case (state)
      RP0:   addr1 = rb;
      RP1:   addr1 = rb + AW'(r) + AW'(1);
      FETCH: begin
        addr1 = cb + AW'(k);
        addr2 = vb + AW'(k);
      end
      MUL:   addr2 = xb + AW'(col);
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == EMIT);
  assign res_data  = res_valid ? acc : '0;
  assign res_row   = res_valid ? r : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      rows    <= '0;
      r       <= '0;
      rb      <= '0;
      cb      <= '0;
      vb      <= '0;
      xb      <= '0;
      k       <= '0;
      end_ptr <= '0;
      col     <= '0;
      val     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rows <= num_rows;
            rb   <= row_base;
            cb   <= col_base;
            vb   <= val_base;
            xb   <= vec_base;
            r    <= '0;
            err  <= 1'b0;
            if (num_rows == '0) begin
              done <= 1'b1;
            end else begin
              state <= RP0;
            end
          end
        end
        RP0: begin
          k     <= dataIn1;
          state <= RP1;
        end
        // A row whose end pointer precedes its start is flagged and emitted as empty.
        RP1: begin
          end_ptr <= dataIn1;
          if (k < dataIn1) begin
            state <= FETCH;
          end else begin
            if (dataIn1 < k) err <= 1'b1;
            state <= EMIT;
          end
        end
        FETCH: begin
          col   <= dataIn1;
          val   <= dataIn2;
          state <= MUL;
        end
        MUL: begin
          k <= k + DW'(1);
          if (k_next < {1'b0, end_ptr}) state <= FETCH;
          else                          state <= EMIT;
        end
        EMIT: begin
          if (res_ready) begin
            r <= r + RW'(1);
            k <= end_ptr;
            if (r_next < {1'b0, rows}) begin
              state <= RP1;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Self-checking bench: directed CSR jobs plus randomized matrices checked
// against a plain-arithmetic SpMV reference kept in the bench.
module tb_csr_spmv_engine;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 16;
  localparam logic [AW-1:0] ROW_B = 32'd0;
  localparam logic [AW-1:0] COL_B = 32'd64;
  localparam logic [AW-1:0] VAL_B = 32'd320;
  localparam logic [AW-1:0] VEC_B = 32'd640;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [RW-1:0] num_rows;
  logic [AW-1:0] row_base, col_base, val_base, vec_base;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] dataIn1, dataIn2;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_row;
  logic          busy, done, err;

  logic [31:0] mem [0:1023];
  logic [31:0] rp [0:16];
  logic [31:0] cv [0:255];
  logic [31:0] vv [0:255];
  logic [31:0] xv [0:15];
  logic [31:0] exp_y [0:15];
  bit          exp_err;
  int          nrows;
  int unsigned checks = 0;
  int unsigned passes = 0;
  int          bcycles;

  csr_spmv_engine #(.DW(DW), .AW(AW), .RW(RW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .num_rows  (num_rows),
    .row_base  (row_base),
    .col_base  (col_base),
    .val_base  (val_base),
    .vec_base  (vec_base),
    .addr1     (addr1),
    .dataIn1   (dataIn1),
    .addr2     (addr2),
    .dataIn2   (dataIn2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_row   (res_row),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  // Two asynchronous read ports onto one shared word memory.
  always_comb begin
    dataIn1 = mem[addr1[9:0]];
    dataIn2 = mem[addr2[9:0]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic clearJob();
    for (int i = 0; i <= 16; i++) rp[i] = '0;
    for (int i = 0; i < 256; i++) begin
      cv[i] = '0;
      vv[i] = '0;
    end
    for (int i = 0; i < 16; i++) xv[i] = '0;
  endtask

  // Reference: y[i] = sum of val[j]*vec[col[j]] over the row's pointer range, mod 2^32.
  task automatic computeExpected();
    longint unsigned s, prod;
    exp_err = 0;
    for (int i = 0; i < 16; i++) exp_y[i] = '0;
    for (int i = 0; i < nrows; i++) begin
      s = 0;
      if (rp[i+1] < rp[i]) begin
        exp_err = 1;
      end else begin
        for (int j = int'(rp[i]); j < int'(rp[i+1]); j++) begin
          prod = {32'b0, vv[j]} * {32'b0, xv[cv[j][3:0]]};
          s = (s + prod) % (64'd1 << 32);
        end
      end
      exp_y[i] = s[31:0];
    end
  endtask

  task automatic loadJob();
    for (int i = 0; i <= 16; i++) mem[ROW_B[9:0] + 10'(i)] = rp[i];
    for (int i = 0; i < 256; i++) begin
      mem[COL_B[9:0] + 10'(i)] = cv[i];
      mem[VAL_B[9:0] + 10'(i)] = vv[i];
    end
    for (int i = 0; i < 16; i++) mem[VEC_B[9:0] + 10'(i)] = xv[i];
    computeExpected();
  endtask

  task automatic setBasic();
    clearJob();
    rp[0] = 0; rp[1] = 2; rp[2] = 2;
    cv[0] = 0; cv[1] = 1;
    vv[0] = 3; vv[1] = 4;
    xv[0] = 5; xv[1] = 6;
    nrows = 2;
  endtask

  task automatic genRandom(input int rows, input int total);
    int cnt [16];
    int ri, p;
    clearJob();
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    if (total > 0) begin
      for (int t = 0; t < total; t++) begin
        ri = $urandom_range(0, rows - 1);
        while (cnt[ri] >= 16) ri = $urandom_range(0, rows - 1);
        cnt[ri]++;
      end
    end else begin
      for (int i = 0; i < rows; i++) cnt[i] = $urandom_range(0, 5);
    end
    p = 0;
    for (int i = 0; i < rows; i++) begin
      rp[i] = p;
      p += cnt[i];
    end
    rp[rows] = p;
    for (int j = 0; j < p; j++) begin
      cv[j] = $urandom_range(0, 15);
      vv[j] = $urandom;
    end
    for (int i = 0; i < 16; i++) xv[i] = $urandom;
    nrows = rows;
  endtask

  task automatic pulseStart(input int rows);
    @(negedge Clk);
    num_rows = RW'(rows);
    row_base = ROW_B;
    col_base = COL_B;
    val_base = VAL_B;
    vec_base = VEC_B;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    num_rows = RW'($urandom);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stall three cycles per result.
  task automatic applyStimulus(input int ready_mode, input bit spurious, output int busy_cycles);
    int got, stall, last_hs;
    bit done_seen, holding;
    logic [DW-1:0] held_data;
    logic [RW-1:0] held_row;
    busy_cycles = 0; got = 0; stall = 0; last_hs = -10;
    done_seen = 0; holding = 0; held_data = '0; held_row = '0;
    res_ready = 1'b0;
    pulseStart(nrows);
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      if (cyc > 0) @(negedge Clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_seen = 1;
        checkOutput("done_latency", 64'(cyc - last_hs), 64'd1);
      end
      start = (spurious && cyc == 3);
      if (holding) begin
        checkOutput("hold_valid", res_valid, 1'b1);
        checkOutput("hold_data", res_data, held_data);
        checkOutput("hold_row", res_row, held_row);
      end
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (res_valid) begin
            res_ready = (stall == 3);
            stall = (stall == 3) ? 0 : stall + 1;
          end else begin
            res_ready = 1'b0;
            stall = 0;
          end
        end
      endcase
      if (res_valid && res_ready) begin
        checkOutput("row_order", res_row, 64'(got));
        checkOutput("row_data", res_data, (got < 16) ? exp_y[got] : 32'hDEAD_BEEF);
        got++;
        last_hs = cyc;
        holding = 0;
      end else if (res_valid) begin
        holding = 1;
        held_data = res_data;
        held_row = res_row;
      end else begin
        holding = 0;
      end
    end
    start = 1'b0;
    if (!done_seen) checkOutput("done_timeout", 1'b0, 1'b1);
    checkOutput("row_count", 64'(got), 64'(nrows));
    checkOutput("err_flag", err, exp_err);
    @(negedge Clk);
    checkOutput("done_pulse_width", done, 1'b0);
    checkOutput("idle_addr1", addr1, '0);
    checkOutput("idle_addr2", addr2, '0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    Rst = 1'b1; start = 1'b0; res_ready = 1'b0; num_rows = '0;
    row_base = '0; col_base = '0; val_base = '0; vec_base = '0;
    nrows = 0;
    repeat (2) @(negedge Clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_valid", res_valid, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_addr1", addr1, '0);
    checkOutput("rst_addr2", addr2, '0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("post_rst_quiet", {busy, res_valid, done}, 3'b000);

    $display("[TB] basic 2x2 job");
    setBasic(); loadJob();
    checkOutput("basic_model_row0", exp_y[0], 32'd39);
    applyStimulus(0, 0, bcycles);

    $display("[TB] backpressure and ignored start");
    applyStimulus(2, 1, bcycles);

    $display("[TB] wrap-around");
    clearJob();
    rp[0] = 0; rp[1] = 1; vv[0] = 32'hFFFF_FFFF; xv[0] = 2; nrows = 1;
    loadJob();
    applyStimulus(0, 0, bcycles);

    $display("[TB] malformed row pointers");
    clearJob();
    rp[0] = 5; rp[1] = 3; nrows = 1;
    loadJob();
    applyStimulus(0, 0, bcycles);
    repeat (2) @(negedge Clk);
    checkOutput("err_sticky", err, 1'b1);

    $display("[TB] zero rows");
    pulseStart(0);
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_valid", res_valid, 1'b0);
    checkOutput("zero_busy", busy, 1'b0);
    checkOutput("zero_err_cleared", err, 1'b0);
    @(negedge Clk);
    checkOutput("zero_done_drop", done, 1'b0);

    $display("[TB] reset during MUL");
    setBasic(); loadJob();
    pulseStart(2);
    res_ready = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (addr2 >= VEC_B && addr2 < VEC_B + 16) found = 1;
      else @(negedge Clk);
    end
    checkOutput("mul_reached", found, 1'b1);
    Rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_valid", res_valid, 1'b0);
    checkOutput("midrst_addr", {addr1, addr2}, '0);
    checkOutput("midrst_data", {res_data, res_row}, '0);
    checkOutput("midrst_flags", {done, err}, 2'b00);
    @(posedge Clk); #1;
    checkOutput("midrst_idle", busy, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("midrst_quiet", {busy, res_valid, done}, 3'b000);
    end
    applyStimulus(1, 0, bcycles);

    $display("[TB] 16x16 regression, 98 nonzeros");
    genRandom(16, 98); loadJob();
    applyStimulus(0, 0, bcycles);
    checkOutput("regress_cycles", 64'(bcycles), 64'(1 + 16 + 2 * 98 + 16));

    $display("[TB] random jobs with random backpressure");
    for (int t = 0; t < 4; t++) begin
      genRandom($urandom_range(1, 8), 0); loadJob();
      applyStimulus(1, 0, bcycles);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
